// File: rtl/io_bridge_pkg.sv
// Shared constants and helpers for the Octavo I/O port FIFO bridge.
// Covers lane slicing, default FIFO geometry, and the FIFO depth sanity check.
package io_bridge_pkg;

    localparam int unsigned DEFAULT_FIFO_DEPTH      = 4;
    localparam int unsigned DEFAULT_FIFO_ADDR_WIDTH = 2;

    function automatic int unsigned lane_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

    // Depth must be a power of two, at least 2, and match the pointer width.
    function automatic bit depth_ok(input int unsigned depth, input int unsigned addr_width);
        return (depth >= 2) && (depth == (32'd1 << addr_width));
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Show-ahead synchronous FIFO: head and flags are valid 1 cycle after a push.
// Push on full and pop on empty are ignored; there is no push-to-head bypass.
module io_sync_fifo #(
    parameter int unsigned WIDTH      = 36,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage is deliberately unreset; a write during reset is harmless as pointers clear.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_port_fifo_bridge.sv
// Per-port read/write FIFOs beside one side of the Octavo I/O ports; 1-cycle latency, outputs registered-derived.
// Backpressure: in_ready/io_write_EF drop when full; sticky error flags exist only with IO_FIFO_ERR_EN.
module io_port_fifo_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned WORD_WIDTH      = 36,
    parameter int unsigned IO_PORT_COUNT   = 8,
    parameter int unsigned FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
    parameter int unsigned FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
    input  logic                                clock,
    input  logic                                reset,
`ifdef IO_FIFO_ERR_EN
    output logic [IO_PORT_COUNT-1:0]            err_underflow,
    output logic [IO_PORT_COUNT-1:0]            err_overflow,
`endif
    output logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_read_data,
    output logic [IO_PORT_COUNT-1:0]            io_read_EF,
    input  logic [IO_PORT_COUNT-1:0]            io_rden,
    input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
    output logic [IO_PORT_COUNT-1:0]            io_write_EF,
    input  logic [IO_PORT_COUNT-1:0]            io_wren,
    input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] in_data,
    input  logic [IO_PORT_COUNT-1:0]            in_valid,
    output logic [IO_PORT_COUNT-1:0]            in_ready,
    output logic [IO_PORT_COUNT*WORD_WIDTH-1:0] out_data,
    output logic [IO_PORT_COUNT-1:0]            out_valid,
    input  logic [IO_PORT_COUNT-1:0]            out_ready
);

    if (!depth_ok(FIFO_DEPTH, FIFO_ADDR_WIDTH)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, >= 2, and equal 2**FIFO_ADDR_WIDTH");
    end

    logic [IO_PORT_COUNT-1:0] rd_empty;
    logic [IO_PORT_COUNT-1:0] rd_full;
    logic [IO_PORT_COUNT-1:0] wr_empty;
    logic [IO_PORT_COUNT-1:0] wr_full;

    for (genvar p = 0; p < IO_PORT_COUNT; p++) begin : g_port
        localparam int unsigned LO = lane_lo(p, WORD_WIDTH);

        // Source -> CPU: pop is the raw strobe; the FIFO ignores it when empty.
        io_sync_fifo #(
            .WIDTH      (WORD_WIDTH),
            .DEPTH      (FIFO_DEPTH),
            .ADDR_WIDTH (FIFO_ADDR_WIDTH)
        ) u_rd_fifo (
            .clock (clock),
            .reset (reset),
            .push  (in_valid[p]),
            .pop   (io_rden[p]),
            .din   (in_data[LO +: WORD_WIDTH]),
            .head  (io_read_data[LO +: WORD_WIDTH]),
            .empty (rd_empty[p]),
            .full  (rd_full[p])
        );

        io_sync_fifo #(
            .WIDTH      (WORD_WIDTH),
            .DEPTH      (FIFO_DEPTH),
            .ADDR_WIDTH (FIFO_ADDR_WIDTH)
        ) u_wr_fifo (
            .clock (clock),
            .reset (reset),
            .push  (io_wren[p]),
            .pop   (out_ready[p]),
            .din   (io_write_data[LO +: WORD_WIDTH]),
            .head  (out_data[LO +: WORD_WIDTH]),
            .empty (wr_empty[p]),
            .full  (wr_full[p])
        );
    end

    assign io_read_EF  = ~rd_empty;
    assign in_ready    = ~rd_full;
    assign io_write_EF = ~wr_full;
    assign out_valid   = ~wr_empty;

`ifdef IO_FIFO_ERR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_underflow <= '0;
            err_overflow  <= '0;
        end else begin
            err_underflow <= err_underflow | (io_rden & rd_empty);
            err_overflow  <= err_overflow | (io_wren & wr_full);
        end
    end
`endif

endmodule
